// File: rtl/syn_fifo_pkg.sv
// Shared constants and elaboration helpers for the syn_fifo_pro synchronous FIFO.
// Read-mode selectors, depth computation and parameter-legality checks.
package syn_fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  localparam int ADDR_WIDTH_MIN = 1;
  localparam int DATA_WIDTH_MIN = 1;
  localparam int AF_LEVEL_MIN   = 1;
  localparam int AE_LEVEL_MIN   = 0;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // AF_LEVEL must lie in 1..D and AE_LEVEL in 0..D-1 so both flags can toggle.
  function automatic bit fifo_params_ok(input int data_width, input int addr_width,
                                        input int af_level, input int ae_level,
                                        input int fwft);
    return (data_width >= DATA_WIDTH_MIN) && (addr_width >= ADDR_WIDTH_MIN) &&
           (af_level >= AF_LEVEL_MIN) && (af_level <= fifo_depth(addr_width)) &&
           (ae_level >= AE_LEVEL_MIN) && (ae_level <= fifo_depth(addr_width) - 1) &&
           ((fwft == FWFT_OFF) || (fwft == FWFT_ON));
  endfunction

endpackage

// File: rtl/syn_fifo_ram.sv
// Simple dual-port storage for syn_fifo_pro: synchronous write, asynchronous read.
// Contents are deliberately left unreset.
module syn_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/syn_fifo_pro.sv
// Single-clock FIFO with occupancy count, almost flags, synchronous flush,
// sticky error flags and standard or first-word-fall-through read mode.
module syn_fifo_pro
  import syn_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = FWFT_OFF,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  flush,
  input  logic                  clr_err,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   fcount,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = PW'(fifo_depth(ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0] AF_CNT    = PW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT    = PW'(AE_LEVEL);

  if (!fifo_params_ok(DATA_WIDTH, ADDR_WIDTH, AF_LEVEL, AE_LEVEL, FWFT)) begin : g_bad_params
    $error("syn_fifo_pro: illegal parameter combination");
  end

  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  wr_acc;
  logic                  rd_acc;

  // Handshake: a write is taken on any edge where wr_en is high, the FIFO is not
  // full and no flush is requested; a read likewise needs rd_en, !empty, !flush.
  // Requests that fail only because of full/empty raise the sticky error flags.
  assign wr_acc = wr_en && !full && !flush;
  assign rd_acc = rd_en && !empty && !flush;

  assign fcount       = wr_ptr - rd_ptr;
  assign empty        = (fcount == '0);
  assign full         = (fcount == DEPTH_CNT);
  assign almost_empty = (fcount <= AE_CNT);
  assign almost_full  = (fcount >= AF_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A fresh error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !flush) overflow <= 1'b1;
      else if (clr_err)            overflow <= 1'b0;
      if (rd_en && empty && !flush) underflow <= 1'b1;
      else if (clr_err)             underflow <= 1'b0;
    end
  end

  syn_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wr_ptr[ADDR_WIDTH-1:0]),
    .wdata(data_in),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(ram_rdata)
  );

  if (FWFT == FWFT_ON) begin : g_fwft
    assign data_out   = ram_rdata;
    assign data_valid = !empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) dout_q <= ram_rdata;
      end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
  end

endmodule

// File: tb/tb_syn_fifo_pro.sv
// Bench for syn_fifo_pro: standard and FWFT instances share one stimulus stream
// and are checked against a queue-based reference model.
module tb_syn_fifo_pro;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;

  logic [DW-1:0] d0_out, d1_out;
  logic          d0_valid, d1_valid;
  logic          e0, f0, ae0, af0, ov0, un0;
  logic          e1, f1, ae1, af1, ov1, un1;
  logic [AW:0]   c0, c1;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_valid;
  logic          exp_ovf;
  logic          exp_unf;

  always #5 clk = ~clk;

  syn_fifo_pro #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(d0_out), .data_valid(d0_valid), .flush(flush), .clr_err(clr_err),
    .empty(e0), .full(f0), .almost_empty(ae0), .almost_full(af0), .fcount(c0),
    .overflow(ov0), .underflow(un0)
  );

  syn_fifo_pro #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(d1_out), .data_valid(d1_valid), .flush(flush), .clr_err(clr_err),
    .empty(e1), .full(f1), .almost_empty(ae1), .almost_full(af1), .fcount(c1),
    .overflow(ov1), .underflow(un1)
  );

  task automatic model_reset();
    exp_q.delete();
    exp_dout  = '0;
    exp_valid = 1'b0;
    exp_ovf   = 1'b0;
    exp_unf   = 1'b0;
  endtask

  // Advance the model by one clock edge, using occupancy from before the edge.
  task automatic model_step(input logic w, input logic [DW-1:0] d, input logic r,
                            input logic f, input logic c);
    bit was_full  = (exp_q.size() == D);
    bit was_empty = (exp_q.size() == 0);
    if (w && was_full && !f)       exp_ovf = 1'b1;
    else if (c)                    exp_ovf = 1'b0;
    if (r && was_empty && !f)      exp_unf = 1'b1;
    else if (c)                    exp_unf = 1'b0;
    if (f) begin
      exp_q.delete();
      exp_valid = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (r && !was_empty) begin
        exp_dout  = exp_q.pop_front();
        exp_valid = 1'b1;
      end
      if (w && !was_full) exp_q.push_back(d);
    end
  endtask

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                     input logic f, input logic c);
    wr_en = w; data_in = d; rd_en = r; flush = f; clr_err = c;
    @(posedge clk);
    model_step(w, d, r, f, c);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_tests++; if (e0 !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", e0); end
    n_tests++; if (f0 !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", f0); end
    n_tests++; if (ae0 !== 1'b1) begin n_fail++; $display("FAIL reset_ae got=%b exp=1", ae0); end
    n_tests++; if (af0 !== 1'b0) begin n_fail++; $display("FAIL reset_af got=%b exp=0", af0); end
    n_tests++; if (c0 !== 5'd0) begin n_fail++; $display("FAIL reset_fcount got=%0d exp=0", c0); end
    n_tests++; if (d0_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", d0_out); end
    n_tests++; if (d0_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", d0_valid); end
    n_tests++; if ({ov0, un0} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", {ov0, un0}); end
    n_tests++; if (d1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwft_valid got=%b exp=0", d1_valid); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      n_tests++; if (c0 !== 5'(i + 1)) begin n_fail++; $display("FAIL fill_fcount got=%0d exp=%0d", c0, i + 1); end
      n_tests++; if (ae0 !== (i + 1 <= AE)) begin n_fail++; $display("FAIL fill_ae n=%0d got=%b", i + 1, ae0); end
      n_tests++; if (af0 !== (i + 1 >= AF)) begin n_fail++; $display("FAIL fill_af n=%0d got=%b", i + 1, af0); end
      n_tests++; if (f0 !== (i + 1 == D)) begin n_fail++; $display("FAIL fill_full n=%0d got=%b", i + 1, f0); end
    end
    cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got=%b exp=1", ov0); end
    n_tests++; if (c0 !== 5'd16) begin n_fail++; $display("FAIL fill_17th_fcount got=%0d exp=16", c0); end
  endtask

  task automatic test_drain();
    logic [DW-1:0] head;
    for (int i = 0; i < D; i++) begin
      head = exp_q[0];
      n_tests++; if (d1_out !== head || d1_valid !== 1'b1) begin
        n_fail++; $display("FAIL drain_fwft_head got=%h/%b exp=%h/1", d1_out, d1_valid, head);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      n_tests++; if (d0_valid !== 1'b1 || d0_out !== 8'(i)) begin
        n_fail++; $display("FAIL drain_data got=%h/%b exp=%h/1", d0_out, d0_valid, 8'(i));
      end
      @(posedge clk); #1;
      exp_valid = 1'b0;
      n_tests++; if (d0_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid_pulse got=%b exp=0", d0_valid); end
    end
    n_tests++; if (e0 !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b exp=1", e0); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_tests++; if (un0 !== 1'b1) begin n_fail++; $display("FAIL drain_underflow got=%b exp=1", un0); end
    n_tests++; if (d0_out !== 8'h0F || d0_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_hold got=%h/%b exp=0f/0", d0_out, d0_valid);
    end
  endtask

  task automatic test_simul();
    logic [DW-1:0] v = 8'h40;
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin cyc(1'b1, v, 1'b0, 1'b0, 1'b0); v++; end
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, v, 1'b1, 1'b0, 1'b0); v++;
      n_tests++; if (c0 !== 5'd5) begin n_fail++; $display("FAIL simul_fcount got=%0d exp=5", c0); end
      n_tests++; if (d0_out !== exp_dout || d0_valid !== 1'b1) begin
        n_fail++; $display("FAIL simul_order got=%h exp=%h", d0_out, exp_dout);
      end
    end
    while (exp_q.size() < D) begin cyc(1'b1, v, 1'b0, 1'b0, 1'b0); v++; end
    cyc(1'b1, v, 1'b1, 1'b0, 1'b0);
    n_tests++; if (c0 !== 5'd15) begin n_fail++; $display("FAIL simul_full_fcount got=%0d exp=15", c0); end
    n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL simul_full_overflow got=%b exp=1", ov0); end
    n_tests++; if (d0_out !== exp_dout) begin n_fail++; $display("FAIL simul_full_data got=%h exp=%h", d0_out, exp_dout); end
  endtask

  task automatic test_fwft();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    n_tests++; if (d1_valid !== 1'b0 || e1 !== 1'b1) begin
      n_fail++; $display("FAIL fwft_flushed got=%b/%b exp=0/1", d1_valid, e1);
    end
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    n_tests++; if (d1_valid !== 1'b1 || d1_out !== 8'hA5) begin
      n_fail++; $display("FAIL fwft_fall_through got=%h/%b exp=a5/1", d1_out, d1_valid);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_tests++; if (e1 !== 1'b1 || d1_valid !== 1'b0) begin
      n_fail++; $display("FAIL fwft_ack got=%b/%b exp=1/0", e1, d1_valid);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i <= D; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    n_tests++; if (c0 !== 5'd9) begin n_fail++; $display("FAIL flush_pre_fcount got=%0d exp=9", c0); end
    cyc(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    n_tests++; if (c0 !== 5'd0 || e0 !== 1'b1) begin n_fail++; $display("FAIL flush_clear got=%0d/%b exp=0/1", c0, e0); end
    n_tests++; if (un0 !== 1'b0 || d0_valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_no_side_effect got=%b/%b exp=0/0", un0, d0_valid);
    end
    n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_ovf got=%b exp=1", ov0); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    n_tests++; if (ov0 !== 1'b0) begin n_fail++; $display("FAIL clr_err got=%b exp=0", ov0); end
    for (int i = 0; i < D; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b1);
    n_tests++; if (ov0 !== 1'b1) begin n_fail++; $display("FAIL clr_err_vs_new_error got=%b exp=1", ov0); end
  endtask

  task automatic test_random();
    logic w, r, f, c;
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 400; i++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      f = ($urandom_range(0, 59) == 0);
      c = ($urandom_range(0, 24) == 0);
      cyc(w, 8'($urandom_range(0, 255)), r, f, c);
      n_tests++; if (c0 !== 5'(exp_q.size()) || c1 !== 5'(exp_q.size())) begin
        n_fail++; $display("FAIL rand_fcount got=%0d/%0d exp=%0d", c0, c1, exp_q.size());
      end
      n_tests++; if ({e0, f0, ae0, af0} !== {exp_q.size() == 0, exp_q.size() == D,
                                            exp_q.size() <= AE, exp_q.size() >= AF}) begin
        n_fail++; $display("FAIL rand_flags got=%b n=%0d", {e0, f0, ae0, af0}, exp_q.size());
      end
      n_tests++; if ({ov0, un0, ov1, un1} !== {exp_ovf, exp_unf, exp_ovf, exp_unf}) begin
        n_fail++; $display("FAIL rand_errors got=%b exp=%b", {ov0, un0, ov1, un1}, {exp_ovf, exp_unf});
      end
      n_tests++; if (d0_valid !== exp_valid || d0_out !== exp_dout) begin
        n_fail++; $display("FAIL rand_std_data got=%h/%b exp=%h/%b", d0_out, d0_valid, exp_dout, exp_valid);
      end
      n_tests++; if (d1_valid !== (exp_q.size() != 0) ||
                     (exp_q.size() != 0 && d1_out !== exp_q[0])) begin
        n_fail++; $display("FAIL rand_fwft_head got=%h/%b", d1_out, d1_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h90 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hB0 + i), 1'b0, 1'b0, 1'b0);
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hCC;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_tests++; if (c0 !== 5'd0 || e0 !== 1'b1 || c1 !== 5'd0) begin
      n_fail++; $display("FAIL async_reset_count got=%0d/%0d exp=0", c0, c1);
    end
    n_tests++; if (d0_out !== 8'h00 || d0_valid !== 1'b0 || d1_valid !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_data got=%h/%b exp=00/0", d0_out, d0_valid);
    end
    n_tests++; if ({ov0, un0} !== 2'b00) begin n_fail++; $display("FAIL async_reset_err got=%b exp=00", {ov0, un0}); end
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h4D, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_tests++; if (d0_out !== 8'h3C || d0_valid !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_first got=%h/%b exp=3c/1", d0_out, d0_valid);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_simul();
    test_fwft();
    test_flush();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
